axi_tx_buf_channel: RTL and testbench
=====================================

AXI_TX_BUF_CHANNEL -- requirements
Module: axi_tx_buf_channel

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits, SHALL be at least 1.
REQ-002 Parameter DEPTH, default 4: buffer entries, SHALL be a power of two and at least 2.
REQ-003 ACLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 ARESETn  input  1  reset, asynchronous assert, active-low.
REQ-005 tx_en  input  1  source offers tx_data this cycle.
REQ-006 tx_data  input  WIDTH  staged source word.
REQ-007 tx_hold  output  1  buffer full; source SHALL NOT assert tx_en while high.
REQ-008 VALID  output  1  bus VALID.
REQ-009 xDATA  output  WIDTH  bus data.
REQ-010 READY  input  1  bus READY from receiver.
REQ-011 level  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Function
REQ-012 Push SHALL occur at an edge where tx_en=1 and tx_hold=0; tx_data is written at the write pointer.
REQ-013 Pop SHALL occur at an edge where VALID=1 and READY=1; the read pointer advances.
REQ-014 Both pointers SHALL wrap modulo DEPTH.
REQ-015 level: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-016 VALID SHALL equal (level != 0); it is never a function of READY.
REQ-017 xDATA SHALL equal the entry at the read pointer, and SHALL NOT be driven to X.
REQ-018 Once VALID is asserted, VALID and xDATA SHALL stay stable until the pop handshake.
REQ-019 tx_hold SHALL equal (level == DEPTH), driven from registered state only; there is no combinational path from READY to tx_hold.
REQ-020 Latency: a word pushed into an empty buffer at edge N SHALL present VALID=1 after edge N; there is no same-cycle bypass.
REQ-021 Occupancy state machine, states EMPTY / PARTIAL / FULL, registered:
  - EMPTY -> PARTIAL on push.
  - PARTIAL -> FULL on push without pop when level = DEPTH-1.
  - PARTIAL -> EMPTY on pop without push when level = 1.
  - FULL -> PARTIAL on pop.
  - Otherwise hold.
REQ-022 Full plus tx_en: the push SHALL be ignored, with no state change and the word dropped; this is a source contract violation.
REQ-023 Full with READY=1: the pop SHALL occur; tx_hold SHALL fall after that edge, and a new push SHALL be accepted only from the following cycle.
REQ-024 Empty with READY=1: no pop; level SHALL stay 0.
REQ-025 Words SHALL leave in push order, with none lost or duplicated.

Reset
REQ-026 ARESETn low SHALL asynchronously force: VALID=0, tx_hold=0, level=0, state EMPTY, read and write pointers 0.
REQ-027 Storage entries SHALL NOT be reset; xDATA value is don't-care while VALID=0.
REQ-028 Reset mid-operation SHALL discard all buffered words.
REQ-029 After deassertion, the first push SHALL be accepted on the first edge.

Structure
REQ-030 Package axi_chan_pkg SHALL hold the occupancy-state enum (EMPTY, PARTIAL, FULL) and the pointer-width helper constant/function.
REQ-031 Storage SHALL be a sub-module tx_buf_mem (DEPTH x WIDTH, one write port, combinational read); control logic stays in axi_tx_buf_channel.
REQ-032 The bench SHALL carry assertions for:
  - VALID stability until handshake.
  - No tx_en while tx_hold=1.
  - level <= DEPTH.

Verification
REQ-033 Streaming (WIDTH=8, DEPTH=4): push 0x11, 0x22, 0x33 with READY=1 -> VALID rises one cycle after the first push; xDATA sequence 0x11, 0x22, 0x33; level returns to 0.
REQ-034 Backpressure fill: READY=0, push 0xA0..0xA3 -> level=4, tx_hold=1, VALID=1, xDATA=0xA0 held constant; a fifth tx_en with 0xA4 is ignored.
REQ-035 Drain from full: from the REQ-034 end state, READY=1 for 4 cycles -> 0xA0..0xA3 in order; tx_hold falls after the first pop; VALID falls after the fourth pop.
REQ-036 Simultaneous events: level=2, READY=1 and push 0x5A in the same cycle -> level stays 2; 0x5A is output third.
REQ-037 Wrap-around: 10 pushes 0x00..0x09 with random READY -> output 0x00..0x09 in order, no loss.
REQ-038 Reset mid-operation: level=3, VALID=1, pulse ARESETn low between edges -> VALID=0, level=0, tx_hold=0 immediately; the next push 0x77 is the next output.

Source files
------------

// File: rtl/axi_chan_pkg.sv
// rtl/axi_chan_pkg.sv - shared types and sizing helpers for the tx buffer channel
package axi_chan_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } occ_state_t;

    // A depth of one entry still needs a one-bit pointer so ports never collapse to zero width.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tx_buf_mem.sv
// rtl/tx_buf_mem.sv - DEPTH x WIDTH buffer storage, one write port, combinational read
module tx_buf_mem
    import axi_chan_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = ptr_width(DEPTH)
) (
    input  logic             ACLK,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // Entries are deliberately left unreset; occupancy tracking decides what is meaningful.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge ACLK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axi_tx_buf_channel.sv
// rtl/axi_tx_buf_channel.sv - registered transmit buffer between a staged source and a VALID/READY bus
module axi_tx_buf_channel
    import axi_chan_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       tx_en,
    input  logic [WIDTH-1:0]           tx_data,
    output logic                       tx_hold,
    output logic                       VALID,
    output logic [WIDTH-1:0]           xDATA,
    input  logic                       READY,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = ptr_width(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LEVEL_LAST = LW'(DEPTH - 1);
    localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);

    occ_state_t       state;
    occ_state_t       state_nxt;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_nxt;
    logic [WIDTH-1:0] rd_data;
    logic             push;
    logic             pop;

    // Both status outputs come straight from the registered state, so READY never reaches tx_hold.
    assign VALID   = (state != EMPTY);
    assign tx_hold = (state == FULL);
    assign push    = tx_en && !tx_hold;
    assign pop     = VALID && READY;
    assign xDATA   = VALID ? rd_data : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (push) state_nxt = PARTIAL;
            PARTIAL: begin
                if (push && !pop && level == LEVEL_LAST) begin
                    state_nxt = FULL;
                end else if (pop && !push && level == LEVEL_ONE) begin
                    state_nxt = EMPTY;
                end
            end
            FULL:    if (pop) state_nxt = PARTIAL;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + LW'(1);
        end else if (pop && !push) begin
            level_nxt = level - LW'(1);
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state  <= EMPTY;
            level  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_nxt;
            level <= level_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    tx_buf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .ACLK    (ACLK),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (tx_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_axi_tx_buf_channel.sv
// tb/tb_axi_tx_buf_channel.sv - self-checking bench for axi_tx_buf_channel against a queue model
module tb_axi_tx_buf_channel;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic             ACLK    = 1'b0;
    logic             ARESETn = 1'b0;
    logic             tx_en   = 1'b0;
    logic [WIDTH-1:0] tx_data = '0;
    logic             READY   = 1'b0;
    logic             tx_hold;
    logic             VALID;
    logic [WIDTH-1:0] xDATA;
    logic [LW-1:0]    level;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] sent[$];
    logic [WIDTH-1:0] got[$];

    bit               contract_en = 1'b1;
    int               rst_epoch   = 0;
    int               prev_epoch  = 0;
    logic             prev_stall  = 1'b0;
    logic [WIDTH-1:0] prev_x      = '0;

    axi_tx_buf_channel #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .tx_en   (tx_en),
        .tx_data (tx_data),
        .tx_hold (tx_hold),
        .VALID   (VALID),
        .xDATA   (xDATA),
        .READY   (READY),
        .level   (level)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_valid"}, 32'(VALID), 32'(model_q.size() != 0));
        chk({tag, "_level"}, 32'(level), 32'(model_q.size()));
        chk({tag, "_hold"}, 32'(tx_hold), 32'(model_q.size() == DEPTH));
        if (model_q.size() != 0) begin
            chk({tag, "_xdata"}, 32'(xDATA), 32'(model_q[0]));
        end
    endtask

    // Entered just after a rising edge; checks mid-cycle, then advances the model across the edge.
    task automatic cycle(input logic en, input logic [WIDTH-1:0] d, input logic rdy, input string tag);
        bit push;
        bit pop;
        tx_en   = en;
        tx_data = d;
        READY   = rdy;
        @(negedge ACLK);
        check_outputs(tag);
        push = en && (model_q.size() < DEPTH);
        pop  = rdy && (model_q.size() != 0);
        if (VALID && rdy) begin
            got.push_back(xDATA);
        end
        @(posedge ACLK);
        if (pop) begin
            void'(model_q.pop_front());
        end
        if (push) begin
            model_q.push_back(d);
            sent.push_back(d);
        end
        #1;
    endtask

    // Property monitors: stability under backpressure, source contract, occupancy bound.
    always @(negedge ACLK) begin
        if (ARESETn) begin
            chk("a_level_max", 32'(level <= LW'(DEPTH)), 32'd1);
            if (contract_en && tx_en) begin
                chk("a_no_en_on_hold", 32'(tx_hold), 32'd0);
            end
            if (prev_stall && prev_epoch == rst_epoch) begin
                chk("a_valid_stable", 32'(VALID), 32'd1);
                chk("a_xdata_stable", 32'(xDATA), 32'(prev_x));
            end
        end
        prev_stall <= ARESETn && VALID && !READY;
        prev_x     <= xDATA;
        prev_epoch <= rst_epoch;
    end

    initial begin
        int idx;
        int guard;
        logic en;

        @(negedge ACLK);
        chk("rst_valid", 32'(VALID), 32'd0);
        chk("rst_hold", 32'(tx_hold), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        @(posedge ACLK);
        #1 ARESETn = 1'b1;

        // Streaming with READY held high
        cycle(1'b1, 8'h11, 1'b1, "stream");
        cycle(1'b1, 8'h22, 1'b1, "stream");
        cycle(1'b1, 8'h33, 1'b1, "stream");
        repeat (2) cycle(1'b0, 8'h00, 1'b1, "stream_tail");

        // Backpressure fill, then a contract-violating push that must be dropped
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0, "fill");
        contract_en = 1'b0;
        cycle(1'b1, 8'hA4, 1'b0, "full_push");
        contract_en = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, "full_hold");

        // Drain from full
        repeat (5) cycle(1'b0, 8'h00, 1'b1, "drain");

        // Simultaneous push and pop at level 2
        cycle(1'b1, 8'h01, 1'b0, "simul_pre");
        cycle(1'b1, 8'h02, 1'b0, "simul_pre");
        cycle(1'b1, 8'h5A, 1'b1, "simul");
        repeat (3) cycle(1'b0, 8'h00, 1'b1, "simul_drain");

        // Wrap-around with random READY; source respects tx_hold
        idx = 0;
        guard = 0;
        while (idx < 10 && guard < 200) begin
            en = (model_q.size() < DEPTH);
            cycle(en, 8'(idx), 1'($urandom_range(0, 1)), "wrap");
            if (en) idx++;
            guard++;
        end
        chk("wrap_all_pushed", 32'(idx), 32'd10);
        repeat (DEPTH + 1) cycle(1'b0, 8'h00, 1'b1, "wrap_drain");

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            en = (model_q.size() < DEPTH) && ($urandom_range(0, 3) != 0);
            cycle(en, 8'($urandom), 1'($urandom_range(0, 2) != 0), "rand");
        end
        repeat (DEPTH + 1) cycle(1'b0, 8'h00, 1'b1, "rand_drain");

        // Reset between edges with three words buffered
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h31 + 8'(i), 1'b0, "pre_rst");
        tx_en = 1'b0;
        #2 ARESETn = 1'b0;
        #1;
        chk("midrst_valid", 32'(VALID), 32'd0);
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_hold", 32'(tx_hold), 32'd0);
        rst_epoch++;
        ARESETn = 1'b1;
        repeat (model_q.size()) void'(sent.pop_back());
        model_q.delete();
        cycle(1'b1, 8'h77, 1'b0, "post_rst");
        cycle(1'b0, 8'h00, 1'b1, "post_rst_out");
        cycle(1'b0, 8'h00, 1'b1, "post_rst_idle");

        chk("sb_count", 32'(got.size()), 32'(sent.size()));
        for (int i = 0; i < got.size() && i < sent.size(); i++) begin
            chk("sb_word", 32'(got[i]), 32'(sent[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
